// File: rtl/traffic_pkg.sv
// Shared types, lamp bit offsets and the cyclic demand search used by the
// N-phase traffic controller.
package traffic_pkg;

   typedef enum logic [1:0] {
      ALL_RED = 2'd0,
      GREEN   = 2'd1,
      YELLOW  = 2'd2,
      FLASH   = 2'd3
   } state_t;

   // Bit offsets of each lamp inside a phase's 3-bit lights field.
   localparam int RED = 2;
   localparam int YEL = 1;
   localparam int GRN = 0;

   // Upper bound on the phase count the search helper can handle.
   localparam int MAX_PHASES = 32;

   // First phase in cyclic order current+1, current+2, ... whose demand bit is
   // set; plain rotation when nothing is requested. Scanning from the far end
   // lets the nearest match overwrite earlier ones.
   function automatic int next_phase(input logic [MAX_PHASES-1:0] demand,
                                     input int current,
                                     input int num_phases);
      int idx;
      int result;
      result = (current + 1 >= num_phases) ? current + 1 - num_phases : current + 1;
      for (int k = MAX_PHASES; k >= 1; k--) begin
         if (k <= num_phases) begin
            idx = current + k;
            if (idx >= num_phases) idx = idx - num_phases;
            if (demand[idx[4:0]]) result = idx;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/traffic_phase_controller_timer.sv
// Loadable down-counter used for interval timing; holds at zero and flags
// expiry so the controller can advance on the next enabled tick.
module phase_timer
   import traffic_pkg::*;
#(
   parameter int TIME_W  = 7,
   parameter int RST_VAL = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic              load,
   input  logic [TIME_W-1:0] load_val,
   output logic              expire,
   output logic [TIME_W-1:0] count
);

   assign expire = (count == '0);

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register samples the pre-edge values regardless of block order.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= TIME_W'(RST_VAL);
      end else if (ce) begin
         if (load)             count <= load_val;
         else if (count != '0) count <= count - TIME_W'(1);
      end
   end

endmodule

// File: rtl/traffic_phase_controller.sv
// N-phase round-robin traffic controller with demand skipping, minimum-green
// clamp, yellow and all-red clearance, and a flashing-yellow fault mode.
module traffic_phase_controller
   import traffic_pkg::*;
#(
   parameter int NUM_PHASES   = 2,
   parameter int TIME_W       = 7,
   parameter int YELLOW_TIME  = 3,
   parameter int ALL_RED_TIME = 1,
   parameter int MIN_GREEN    = 4,
   localparam int AP_W        = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ce,
   input  logic [TIME_W-1:0]            green_time,
   input  logic [NUM_PHASES-1:0]        demand,
   input  logic                         flash,
   output logic [3*NUM_PHASES-1:0]      lights,
   output logic [NUM_PHASES*TIME_W-1:0] time_left,
   output logic [AP_W-1:0]              active_phase
);

   state_t                       state, state_nxt;
   logic [AP_W-1:0]              phase_nxt;
   logic                         toggle, toggle_nxt;
   logic                         load, expire;
   logic [TIME_W-1:0]            load_val, count, timer_nxt, green_dur;
   logic [3*NUM_PHASES-1:0]      lights_nxt;
   logic [NUM_PHASES*TIME_W-1:0] time_left_nxt;

   // A requested green of zero falls under the clamp as well.
   assign green_dur = (green_time < TIME_W'(MIN_GREEN)) ? TIME_W'(MIN_GREEN) : green_time;

   phase_timer #(
      .TIME_W  (TIME_W),
      .RST_VAL (ALL_RED_TIME - 1)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .ce       (ce),
      .load     (load),
      .load_val (load_val),
      .expire   (expire),
      .count    (count)
   );

   // NOTE: every signal written here gets a default first, so no path through
   // the block leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_nxt  = state;
      phase_nxt  = active_phase;
      load       = 1'b0;
      load_val   = '0;
      toggle_nxt = toggle;
      if (ce) begin
         if (state == FLASH) toggle_nxt = ~toggle;
         if (flash) begin
            state_nxt = FLASH;
         end else if (state == FLASH) begin
            state_nxt = ALL_RED;
            load      = 1'b1;
            load_val  = TIME_W'(ALL_RED_TIME - 1);
         end else if (expire) begin
            load = 1'b1;
            unique case (state)
               ALL_RED: begin
                  state_nxt = GREEN;
                  phase_nxt = AP_W'(next_phase(MAX_PHASES'(demand), int'(active_phase), NUM_PHASES));
                  load_val  = green_dur - TIME_W'(1);
               end
               GREEN: begin
                  state_nxt = YELLOW;
                  load_val  = TIME_W'(YELLOW_TIME - 1);
               end
               default: begin
                  state_nxt = ALL_RED;
                  load_val  = TIME_W'(ALL_RED_TIME - 1);
               end
            endcase
         end
      end
   end

   // Outputs are decoded from next-state values so they register alongside it.
   always_comb begin
      timer_nxt = count;
      if (load)                   timer_nxt = load_val;
      else if (ce && count != '0) timer_nxt = count - TIME_W'(1);

      lights_nxt    = '0;
      time_left_nxt = '0;
      for (int p = 0; p < NUM_PHASES; p++) begin
         if (state_nxt == FLASH) begin
            lights_nxt[3*p+YEL] = toggle_nxt;
         end else if (p == int'(phase_nxt) && state_nxt == GREEN) begin
            lights_nxt[3*p+GRN]              = 1'b1;
            time_left_nxt[p*TIME_W +: TIME_W] = timer_nxt + TIME_W'(1);
         end else if (p == int'(phase_nxt) && state_nxt == YELLOW) begin
            lights_nxt[3*p+YEL]              = 1'b1;
            time_left_nxt[p*TIME_W +: TIME_W] = timer_nxt + TIME_W'(1);
         end else begin
            lights_nxt[3*p+RED] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ALL_RED;
         active_phase <= AP_W'(NUM_PHASES - 1);
         toggle       <= 1'b0;
         lights       <= {NUM_PHASES{3'b100}};
         time_left    <= '0;
      end else begin
         state        <= state_nxt;
         active_phase <= phase_nxt;
         toggle       <= toggle_nxt;
         lights       <= lights_nxt;
         time_left    <= time_left_nxt;
      end
   end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Randomised scoreboard bench: a tick-level model of the signal plan predicts
// every registered output, a monitor compares one cycle after each edge.
module tb_traffic_phase_controller;

   localparam int N     = 4;
   localparam int TW    = 7;
   localparam int YEL_T = 3;
   localparam int AR_T  = 1;
   localparam int MIN_G = 4;

   logic              clk = 1'b0;
   logic              rst, ce, flash;
   logic [TW-1:0]     green_time;
   logic [N-1:0]      demand;
   logic [3*N-1:0]    lights;
   logic [N*TW-1:0]   time_left;
   logic [1:0]        active_phase;

   traffic_phase_controller #(
      .NUM_PHASES   (N),
      .TIME_W       (TW),
      .YELLOW_TIME  (YEL_T),
      .ALL_RED_TIME (AR_T),
      .MIN_GREEN    (MIN_G)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ce           (ce),
      .green_time   (green_time),
      .demand       (demand),
      .flash        (flash),
      .lights       (lights),
      .time_left    (time_left),
      .active_phase (active_phase)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3*N-1:0]  lights;
      logic [N*TW-1:0] tl;
      logic [1:0]      ap;
      int              cyc;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   armed    = 0;

   // Monitor: one expected record per clock edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() == 0) begin
            if (armed) begin
               checks++;
               failures++;
               $display("FAIL scoreboard_empty t=%0t got=none required=record", $time);
            end
         end else begin
            e = q.pop_front();
            checks += 3;
            if (lights !== e.lights) begin
               failures++;
               $display("FAIL lights cyc=%0d got=%b required=%b", e.cyc, lights, e.lights);
            end
            if (time_left !== e.tl) begin
               failures++;
               $display("FAIL time_left cyc=%0d got=%h required=%h", e.cyc, time_left, e.tl);
            end
            if (active_phase !== e.ap) begin
               failures++;
               $display("FAIL active_phase cyc=%0d got=%0d required=%0d", e.cyc, active_phase, e.ap);
            end
         end
      end
   end

   // Reference model: what a signal plan does, in ticks remaining.
   typedef enum {M_RED, M_GO, M_CAUTION, M_BLINK} mode_t;
   mode_t mode;
   int    left;
   int    ap;
   bit    tog;

   function automatic int pick(input logic [N-1:0] d, input int cur);
      for (int k = 1; k <= N; k++)
         if (d[(cur + k) % N]) return (cur + k) % N;
      return (cur + 1) % N;
   endfunction

   task automatic model_tick();
      exp_t e;
      int   gt;
      if (rst) begin
         mode = M_RED; left = AR_T; ap = N - 1; tog = 0;
      end else if (ce) begin
         if (mode == M_BLINK) tog = ~tog;
         if (flash) begin
            mode = M_BLINK;
         end else if (mode == M_BLINK) begin
            mode = M_RED; left = AR_T;
         end else begin
            left--;
            if (left == 0) begin
               case (mode)
                  M_RED: begin
                     ap   = pick(demand, ap);
                     gt   = int'(green_time);
                     mode = M_GO;
                     left = (gt < MIN_G) ? MIN_G : gt;
                  end
                  M_GO:    begin mode = M_CAUTION; left = YEL_T; end
                  default: begin mode = M_RED;     left = AR_T;  end
               endcase
            end
         end
      end
      e.lights = '0;
      e.tl     = '0;
      e.ap     = 2'(ap);
      e.cyc    = 0;
      for (int p = 0; p < N; p++) begin
         if (mode == M_BLINK)                  e.lights[3*p+1] = tog;
         else if (p == ap && mode == M_GO)     e.lights[3*p]   = 1'b1;
         else if (p == ap && mode == M_CAUTION) e.lights[3*p+1] = 1'b1;
         else                                  e.lights[3*p+2] = 1'b1;
         if (p == ap && (mode == M_GO || mode == M_CAUTION)) e.tl[p*TW +: TW] = TW'(left);
      end
      q.push_back(e);
   endtask

   initial begin
      int ce_mode;
      int flash_hold;
      rst = 1'b1; ce = 1'b1; flash = 1'b0; green_time = 7'd5; demand = '0;
      flash_hold = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (c < 2) begin
            rst = 1'b1;
         end else if (c < 40) begin
            rst = 1'b0; ce = 1'b1; demand = '0; green_time = 7'd5; flash = 1'b0;
         end else begin
            ce_mode = (c / 200) % 3;
            ce  = (ce_mode == 0) ? 1'b1 : (ce_mode == 1) ? (c % 4 == 0) : 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 299) == 0);
            if (c % 10 == 0) demand = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom);
            if (c % 15 == 0) green_time = TW'($urandom_range(0, 12));
            if (flash_hold > 0) begin
               flash_hold--;
               flash = (flash_hold != 0);
            end else if ($urandom_range(0, 79) == 0) begin
               flash_hold = $urandom_range(3, 12);
               flash = 1'b1;
            end
         end
         model_tick();
         q[q.size()-1].cyc = c;
         armed = 1'b1;
      end
      @(negedge clk);
      armed = 1'b0;
      @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
- Parametrised N-phase traffic-light controller. Successor to the fixed two-direction (NS/EW) light block.
- Adds the following:
  - a configurable phase count;
  - separate yellow and all-red clearance intervals;
  - a minimum-green clamp;
  - demand-based phase skipping;
  - a flashing-yellow fault mode.
- Advances only on `ce` ticks, driven by the shared tick/counter enable. Outputs drive the lamp drivers and the per-phase countdown displays.

Parameters:
- NUM_PHASES, 2, number of conflicting approaches served round-robin (≥2)
- TIME_W, 7, width of timers and countdown outputs
- YELLOW_TIME, 3, yellow duration in ce ticks (≥1)
- ALL_RED_TIME, 1, all-red clearance duration in ce ticks (≥1)
- MIN_GREEN, 4, minimum green duration in ce ticks (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ce  in  1  tick enable; all state and timer advance is qualified by ce
- green_time  in  TIME_W  requested green duration, sampled on entry to GREEN
- demand  in  NUM_PHASES  per-phase vehicle/pedestrian request, level sensitive
- flash  in  1  fault/night request: flashing yellow on all phases
- lights  out  3*NUM_PHASES  per phase p: [3p+2]=red, [3p+1]=yellow, [3p]=green
- time_left  out  NUM_PHASES*TIME_W  per phase p at [p*TIME_W +: TIME_W]: remaining ticks of its current green/yellow interval, 0 otherwise
- active_phase  out  max(1,clog2(NUM_PHASES))  index of the phase last/currently granted

Behaviour:

Reset and general rules:
- One clock domain (`clk`). Reset is synchronous, active-high, on `rst`.
- On `rst`:
  - state=ALL_RED, timer=ALL_RED_TIME-1;
  - active_phase=NUM_PHASES-1, so the first grant goes to phase 0;
  - flash_toggle=0.
- Outputs are registered. After reset, lights = all red (N=2: 6'b100100) and time_left = 0.
- `rst` dominates `ce` and `flash`. Reset mid-interval abandons the interval immediately.
- With ce=0, every register holds.

States: ALL_RED, GREEN, YELLOW, FLASH.
- Each timed state is entered with timer=D-1. On each ce tick, timer decrements. A ce tick with timer==0 performs the transition. Each state therefore lasts exactly D ce ticks.
- ALL_RED (D=ALL_RED_TIME) → GREEN.
  - Next phase = first p in cyclic order active_phase+1, +2, … with demand[p]=1.
  - If demand==0, next phase = (active_phase+1) mod NUM_PHASES (plain rotation).
  - A phase whose own bit is the only one set is re-granted.
- GREEN (D = max(green_time, MIN_GREEN), with green_time==0 also treated as MIN_GREEN) → YELLOW.
  - green_time is latched at the entry tick. Later changes take effect on the next GREEN only.
- YELLOW (D=YELLOW_TIME) → ALL_RED.
- FLASH:
  - Entered from any state on a ce tick with flash=1. Flash has priority over timer expiry on the same tick.
  - While in FLASH, flash_toggle inverts every ce tick.
  - Lights: yellow = flash_toggle on every phase; red = 0; green = 0.
  - Exit on a ce tick with flash=0 → ALL_RED with timer=ALL_RED_TIME-1. active_phase is unchanged, so rotation resumes after the last granted phase.

Outputs:
- lights: active_phase green in GREEN, yellow in YELLOW; all other phases red.
- time_left[active_phase] = timer+1 in GREEN/YELLOW. All other entries, and all entries in ALL_RED/FLASH, are 0.
- All timer arithmetic is unsigned TIME_W. D is never 0, so there is no wrap-around.

Decomposition:
- Package traffic_pkg holds:
  - the state enum (ALL_RED, GREEN, YELLOW, FLASH);
  - lamp bit-offset constants (RED=2, YEL=1, GRN=0);
  - a function next_phase(demand, current) implementing the cyclic priority search.
- One natural sub-module: phase_timer (load value, ce, expire flag, count output), reusable for the countdown displays.

Test Plan (defaults, ce=1 every cycle unless stated, green_time=5):
- Reset release, demand=0 → ALL_RED 1 cycle (lights=6'b100100).
  - Then phase 0 GREEN 5 cycles: lights=6'b100001, time_left[0]=5,4,3,2,1.
  - Then YELLOW 3 cycles: lights=6'b100010.
  - Then ALL_RED 1 cycle, then phase 1 GREEN: lights=6'b001100.
- green_time=2 → GREEN lasts 4 cycles (MIN_GREEN). green_time changed to 9 mid-green → current green still ends at 4 cycles; next green lasts 9.
- NUM_PHASES=4, phase 0 in GREEN, demand=4'b1000 → after YELLOW and ALL_RED, active_phase=3; phases 1 and 2 stay red throughout.
- flash=1 during GREEN → next cycle all phases red=0 and green=0, yellow toggling 0,1,0,1…; time_left all 0.
  - flash=0 → ALL_RED 1 cycle, then the next phase after the pre-flash active_phase goes GREEN.
- ce pulsed every 4th cycle → every interval is 4× longer in clk cycles. Outputs are stable between ce ticks.
- rst asserted during YELLOW → next cycle all red, active_phase=NUM_PHASES-1; the first grant after release is phase 0.
